imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-side responder for the single-cycle RISC-V core. It owns the instruction memory and answers the core's `PC` with a combinational `instr`. After reset it accepts a program over a valid/ready load stream while holding the core in reset, then releases the core. Fetches beyond the loaded image return a NOP instead of stale data.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory size in 32-bit words; power of two, from 4 to 65536.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PC`  in  32  fetch byte address from the core.
- `instr`  out  32  instruction for `PC`; combinational.
- `cpu_reset`  out  1  registered; holds the core in reset until the load completes.
- `ld_valid`  in  1  the load word on `ld_data` is valid.
- `ld_data`  in  32  program word; words arrive in ascending address order from word 0.
- `ld_last`  in  1  marks the final program word; sampled only on a handshake.
- `ld_ready`  out  1  the block can accept a load word.
- `loaded`  out  1  registered; high while in S_RUN.
- `fault`  out  1  sticky fetch fault (see Configuration).

## Operation
- State machine with two states:
  - S_LOAD is entered on `reset`.
  - S_RUN is entered after the last word is accepted.
  - S_RUN is left only by `reset`.
- Reset values:
  - state = S_LOAD, `wr_ptr` = 0, `count` = 0.
  - `cpu_reset` = 1, `loaded` = 0, `fault` = 0.
- Memory contents are not cleared by reset. The valid region is tracked by `count` alone.
- S_LOAD behaviour:
  - `ld_ready` = 1.
  - A handshake occurs when `ld_valid && ld_ready` at a clock edge.
  - On a handshake: `mem[wr_ptr]` ← `ld_data`, then `wr_ptr` and `count` each increment by 1.
  - The transition to S_RUN happens on a handshake with `ld_last` = 1, or on a handshake when `wr_ptr` == DEPTH-1 (memory full, so `ld_last` is implied).
- S_RUN behaviour:
  - `ld_ready` = 0; `ld_valid` is ignored.
  - `cpu_reset` = 0, `loaded` = 1.
- Fetch:
  - `idx` = `PC[ADDR_W+1:2]`.
  - If `PC[31:2]` < `count`, `instr` = `mem[idx]`; otherwise `instr` = NOP (0x00000013).
  - All `PC` bits are compared, so there is no wrap-around aliasing.
  - In S_LOAD, `instr` = NOP regardless of `PC`.
- Width rules:
  - `count` is ADDR_W+1 bits wide, so it can represent DEPTH.
  - `wr_ptr` is ADDR_W bits wide and never wraps, because a write at DEPTH-1 always ends the load.
- A zero-length program is impossible: at least one handshake is required to leave S_LOAD.

## Timing
- Fetch latency is zero cycles: `instr` is combinational from `PC`, `count` and memory.
- A word written at edge N is readable after edge N.
- `ld_ready` falls in the cycle after the final handshake.
- `cpu_reset` deasserts and `loaded` asserts on the same edge as the move into S_RUN. The core's first fetch at PC = 0 happens in that cycle.
- `reset` asserted mid-load:
  - On the next edge, `count` = 0 and `wr_ptr` = 0, and loading restarts from word 0.
  - Previously written words are unreachable until they are reloaded.
- `reset` asserted in S_RUN re-enters S_LOAD and reasserts `cpu_reset` on that edge.
- `ld_last` seen with `ld_valid` high but `ld_ready` low has no effect.

## Configuration
- `IMEM_FAULT_EN` defined:
  - A fetch in S_RUN with `PC[1:0]` != 0 forces `instr` = NOP.
  - `fault` is set on the next edge when either `PC[1:0]` != 0, or `PC[31:2]` ≥ `count`.
  - `fault` is sticky and is cleared only by `reset`.
- `IMEM_FAULT_EN` undefined:
  - `fault` is tied to 0.
  - `PC[1:0]` is ignored; a misaligned PC reads `mem[idx]`.
  - The out-of-range NOP rule still applies.

## Structure
- Package `imem_pkg` holds:
  - `NOP_INSTR` = 32'h00000013.
  - `ADDR_W` = $clog2(DEPTH), provided as a function.
  - The state enum {S_LOAD, S_RUN}.
- Sub-module `imem_ram`:
  - DEPTH×32 storage.
  - One synchronous write port and one asynchronous read port.
  - No reset.
- Top level holds the FSM, `wr_ptr`, `count`, the fetch mux and the fault logic.

## Test plan
- Load with `ld_last` on the final word:
  - Stimulus: reset, then load 0x00500093, 0x00100113, 0x002081b3 back-to-back.
  - Required: `ld_ready` = 0 and `cpu_reset` = 0 the cycle after the third handshake.
  - Required fetches: PC = 0/4/8 return the three words in order; PC = 12 returns 0x00000013.
- Gapped `ld_valid`:
  - Stimulus: `ld_valid` toggles 1,0,0,1,0,1 (with `ld_last` on the final 1).
  - Required: exactly 3 writes, `count` = 3, and the words land at indices 0, 1, 2.
- Memory full:
  - Stimulus: DEPTH = 4, load 4 words with `ld_last` = 0.
  - Required: the block enters S_RUN after the 4th word and `ld_ready` = 0.
  - Required: a 5th `ld_valid` is not accepted.
- Reset mid-load:
  - Stimulus: load 2 words, pulse `reset`, then load 1 word 0xDEADBEEF with `ld_last`.
  - Required: PC = 0 returns 0xDEADBEEF; PC = 4 returns NOP.
- Misaligned fetch:
  - Stimulus: PC = 0x6 in S_RUN with 3 words loaded.
  - Required with `IMEM_FAULT_EN`: `instr` = NOP, `fault` = 1, and `fault` stays high after PC returns to 0.
  - Required without `IMEM_FAULT_EN`: `instr` = word 1 and `fault` = 0.
- `reset` in S_RUN:
  - Required: `cpu_reset` = 1, `loaded` = 0 and `ld_ready` = 1 after the edge.
  - Required: PC = 0 returns NOP.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants, types and helpers for the instruction
//                memory loader (NOP encoding, address width, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // addi x0, x0, 0 : returned for any fetch outside the loaded image
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Word-address width for a memory of the given depth (power of two)
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : DEPTH x 32 instruction storage, one synchronous write port
//                and one asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [addr_w(DEPTH)-1:0] i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic [addr_w(DEPTH)-1:0] i_raddr,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write port: a word written on edge N is visible right after edge N
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-side responder. Accepts a program over a
//                valid/ready stream while holding the core in reset, then
//                releases the core and serves combinational fetches. Fetches
//                beyond the loaded image return a NOP.
//                Optional macro IMEM_FAULT_EN: misaligned fetches return NOP
//                and any bad fetch in run mode sets a sticky fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] instr,
    output logic        cpu_reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        loaded,
    output logic        fault
);

    localparam int                ADDR_W     = addr_w(DEPTH);
    localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_cpu_reset;
    logic              r_loaded;
    logic              w_handshake;
    logic              w_in_range;
    logic              w_bad_align;
    logic [31:0]       w_rd_data;

    assign ld_ready    = (r_state == S_LOAD);
    assign w_handshake = ld_valid && ld_ready;
    // Full 30-bit word-address compare: no aliasing past the image
    assign w_in_range  = (PC[31:2] < 30'(r_count));
    assign cpu_reset   = r_cpu_reset;
    assign loaded      = r_loaded;

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_handshake && !reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (ld_data),
        .i_raddr (PC[ADDR_W+1:2]),
        .o_rdata (w_rd_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a last-marked word or a write into the final slot ends loading
    always_comb begin
        w_state_next = r_state;
        if ((r_state == S_LOAD) && w_handshake &&
            (ld_last || (r_wr_ptr == c_PTR_LAST))) begin
            w_state_next = S_RUN;
        end
    end

    // Load pointer, valid-word count and registered core-control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_count  <= r_count + c_CNT_ONE;
            end
            r_cpu_reset <= (w_state_next == S_LOAD);
            r_loaded    <= (w_state_next == S_RUN);
        end
    end

`ifdef IMEM_FAULT_EN
    logic r_fault;

    assign w_bad_align = |PC[1:0];
    assign fault       = r_fault;

    // Sticky fault on any misaligned or out-of-image fetch while running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if ((r_state == S_RUN) && (w_bad_align || !w_in_range)) begin
            r_fault <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_bad_align = 1'b0;
    assign fault       = 1'b0;
    assign w_unused    = ^PC[1:0];
`endif

    // Fetch mux: NOP while loading, outside the image, or on a rejected fetch
    always_comb begin
        instr = NOP_INSTR;
        if ((r_state == S_RUN) && w_in_range && !w_bad_align) begin
            instr = w_rd_data;
        end
    end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader (DEPTH = 4). A small
//                behavioural model predicts fetch results, which are queued
//                when a fetch is driven and compared when instr settles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;
`ifdef IMEM_FAULT_EN
    localparam bit          c_FEN   = 1'b1;
`else
    localparam bit          c_FEN   = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        cpu_reset;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        loaded;
    logic        fault;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_mem [c_DEPTH];
    int          m_count;
    int          m_ptr;
    bit          m_run;
    bit          m_fault;
    logic [31:0] exp_q [$];

    imem_loader #(
        .DEPTH (c_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .instr     (instr),
        .cpu_reset (cpu_reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .loaded    (loaded),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, updating the model with what the DUT sees at the edge
    task automatic tick();
        if (reset) begin
            m_run = 0; m_count = 0; m_ptr = 0; m_fault = 0;
        end else if (m_run) begin
            if (c_FEN && ((PC[1:0] != 2'b00) || (int'(PC[31:2]) >= m_count)))
                m_fault = 1;
        end else if (ld_valid) begin
            m_mem[m_ptr] = ld_data;
            m_count++;
            m_ptr++;
            if (ld_last || (m_ptr == c_DEPTH)) m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input string tag);
        logic [31:0] e;
        logic [1:0]  idx;
        logic [31:0] got;
        idx = pc[3:2];
        if (!m_run || (pc[31:2] >= 30'(m_count)) || (c_FEN && pc[1:0] != 2'b00))
            e = c_NOP;
        else
            e = m_mem[idx];
        exp_q.push_back(e);
        PC = pc;
        #1;
        got = exp_q.pop_front();
        chk(tag, instr, got);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic ctrl(input string tag);
        chk({tag, "_ld_ready"},  32'(ld_ready),  32'(!m_run));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!m_run));
        chk({tag, "_loaded"},    32'(loaded),    32'(m_run));
        chk({tag, "_fault"},     32'(fault),     32'(m_fault));
    endtask

    initial begin
        reset = 1'b1; PC = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        m_run = 0; m_count = 0; m_ptr = 0; m_fault = 0;
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        ctrl("rst");
        chk("rst_cpu_reset_const", 32'(cpu_reset), 32'd1);
        fetch(32'h0, "rst_pc0");

        // Back-to-back load with ld_last on word 3
        ld_valid = 1'b1;
        ld_data = 32'h0050_0093; ld_last = 1'b0; tick();
        ld_data = 32'h0010_0113; tick();
        chk("b2b_still_loading", 32'(ld_ready), 32'd1);
        ld_data = 32'h0020_81b3; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ctrl("b2b_done");
        chk("b2b_ready_low", 32'(ld_ready), 32'd0);
        fetch(32'h0, "b2b_pc0");
        fetch(32'h4, "b2b_pc4");
        fetch(32'h8, "b2b_pc8");
        chk("b2b_pc8_const", instr, 32'h0020_81b3);
        fetch(32'hC, "b2b_pc12");
        chk("b2b_pc12_nop", instr, c_NOP);
        fetch(32'h1000_0000, "b2b_far_pc");
        tick();

        // Misaligned fetch in run mode
        fetch(32'h6, "mis_pc6");
        tick();
        chk("mis_fault", 32'(fault), 32'(c_FEN));
        fetch(32'h0, "mis_pc0");
        tick();
        chk("mis_fault_sticky", 32'(fault), 32'(m_fault));

        // Reset while running
        PC = 32'h0;
        do_reset();
        ctrl("run_rst");
        fetch(32'h0, "run_rst_pc0");

        // Gapped ld_valid: 1,0,0,1,0,1
        ld_data = 32'h1111_0001; ld_valid = 1'b1; tick();
        ld_data = 32'hBAD0_0001; ld_valid = 1'b0; tick();
        ld_data = 32'hBAD0_0002; tick();
        ld_data = 32'h1111_0002; ld_valid = 1'b1; tick();
        ld_data = 32'hBAD0_0003; ld_valid = 1'b0; ld_last = 1'b1; tick();
        chk("gap_not_done", 32'(ld_ready), 32'd1);
        ld_data = 32'h1111_0003; ld_valid = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ctrl("gap_done");
        fetch(32'h0, "gap_pc0");
        fetch(32'h4, "gap_pc4");
        fetch(32'h8, "gap_pc8");
        fetch(32'hC, "gap_pc12");

        // Reset mid-load, then a single-word program
        PC = 32'h0;
        do_reset();
        ld_valid = 1'b1;
        ld_data = 32'hAAAA_0000; tick();
        ld_data = 32'hAAAA_0001; tick();
        ld_valid = 1'b0;
        do_reset();
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ctrl("mid_done");
        fetch(32'h0, "mid_pc0");
        chk("mid_pc0_const", instr, 32'hDEAD_BEEF);
        fetch(32'h4, "mid_pc4");

        // Memory full: four words with ld_last low
        PC = 32'h0;
        do_reset();
        ld_valid = 1'b1; ld_last = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
            ld_data = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        ctrl("full_done");
        // A fifth word (even with ld_last) must be ignored in run mode
        ld_data = 32'hFFFF_FFFF; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ctrl("full_extra");
        for (int i = 0; i < c_DEPTH; i++) fetch(32'(i * 4), "full_fetch");
        fetch(32'h10, "full_pc16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
